// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, types and row-decode helpers for matrix_capture
package matrix_pkg;

    localparam int MATRIX_WIDTH = 16;
    localparam int ROW_IDX_W    = 4;

    typedef logic [MATRIX_WIDTH-1:0] row_vec_t;
    typedef logic [ROW_IDX_W-1:0]    row_idx_t;

    // True when exactly one row select bit is set.
    function automatic logic is_onehot(row_vec_t v);
        return (v != '0) && ((v & (v - row_vec_t'(1))) == '0);
    endfunction

    // Position of the set bit; only meaningful when v is one-hot.
    function automatic row_idx_t onehot_to_idx(row_vec_t v);
        row_idx_t idx;
        idx = '0;
        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            if (v[i]) begin
                idx = idx | row_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/matrix_capture_if.sv
// rtl/matrix_capture_if.sv - LED-matrix serial lines as driven by the screen block
interface matrix_capture_if;

    logic rclk;
    logic rsdi;
    logic oeb;
    logic csdi;
    logic cclk;
    logic le;

    // The screen driver owns every line.
    modport master (
        output rclk, rsdi, oeb, csdi, cclk, le
    );

    // The capture side only observes them.
    modport slave (
        input rclk, rsdi, oeb, csdi, cclk, le
    );

endinterface

// File: rtl/matrix_capture_sync_edge.sv
// rtl/matrix_capture_sync_edge.sv - flop synchroniser with rising-edge detector
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the raw line through the synchroniser; remember last synced value.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and history registers; history clears to 0 so a line
    // held high across reset release yields one rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/matrix_capture.sv
// rtl/matrix_capture.sv - LED-matrix serial receiver rebuilding a readable frame buffer
module matrix_capture
    import matrix_pkg::*;
#(
    parameter int WIDTH       = MATRIX_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    matrix_capture_if.slave      lines,
    input  logic [ROW_IDX_W-1:0] rd_row,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 row_commit,
    output logic [ROW_IDX_W-1:0] row_index,
    output logic                 frame_done,
    output logic                 err_multirow,
    output logic                 blank
);

    logic rclk_s, rclk_rise;
    logic rsdi_s, rsdi_rise;
    logic oeb_s,  oeb_rise;
    logic csdi_s, csdi_rise;
    logic cclk_s, cclk_rise;
    logic le_s,   le_rise;
    logic unused_rises;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rclk (
        .clk(clk), .rst_n(reset), .d(lines.rclk), .level(rclk_s), .rise(rclk_rise));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rsdi (
        .clk(clk), .rst_n(reset), .d(lines.rsdi), .level(rsdi_s), .rise(rsdi_rise));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_oeb (
        .clk(clk), .rst_n(reset), .d(lines.oeb),  .level(oeb_s),  .rise(oeb_rise));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_csdi (
        .clk(clk), .rst_n(reset), .d(lines.csdi), .level(csdi_s), .rise(csdi_rise));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cclk (
        .clk(clk), .rst_n(reset), .d(lines.cclk), .level(cclk_s), .rise(cclk_rise));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_le (
        .clk(clk), .rst_n(reset), .d(lines.le),   .level(le_s),   .rise(le_rise));

    // Data and enable lines are used as levels, clocks as edges only.
    assign unused_rises = rsdi_rise | oeb_rise | csdi_rise | rclk_s | cclk_s | le_s;

    logic [WIDTH-1:0]     col_sr_q,    col_sr_d;
    logic [WIDTH-1:0]     row_sr_q,    row_sr_d;
    logic [WIDTH-1:0]     col_latch_q, col_latch_d;
    logic                 pend_q,      pend_d;
    logic [ROW_IDX_W-1:0] pend_idx_q,  pend_idx_d;
    logic                 err_q,       err_d;
    logic [WIDTH-1:0]     frame_q [WIDTH];
    logic [WIDTH-1:0]     frame_d [WIDTH];
    logic                 row_commit_q, row_commit_d;
    logic                 frame_done_q, frame_done_d;
    logic [ROW_IDX_W-1:0] row_index_q,  row_index_d;
    logic [WIDTH-1:0]     rd_data_q,    rd_data_d;

    // Stage 1: shift registers, latch, and row decode on the same-cycle next values.
    always_comb begin
        col_sr_d    = col_sr_q;
        row_sr_d    = row_sr_q;
        col_latch_d = col_latch_q;
        pend_d      = 1'b0;
        pend_idx_d  = pend_idx_q;
        err_d       = err_q;
        if (cclk_rise) begin
            col_sr_d = {col_sr_q[WIDTH-2:0], csdi_s};
        end
        if (rclk_rise) begin
            row_sr_d = {row_sr_q[WIDTH-2:0], rsdi_s};
        end
        if (le_rise) begin
            col_latch_d = col_sr_d;
            if (is_onehot(row_sr_d)) begin
                pend_d     = 1'b1;
                pend_idx_d = onehot_to_idx(row_sr_d);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Stage 2: frame write and commit pulses; read port samples pre-write contents.
    always_comb begin
        frame_d      = frame_q;
        row_commit_d = 1'b0;
        frame_done_d = 1'b0;
        row_index_d  = row_index_q;
        if (pend_q) begin
            frame_d[pend_idx_q] = col_latch_q;
            row_commit_d        = 1'b1;
            row_index_d         = pend_idx_q;
            frame_done_d        = (pend_idx_q == ROW_IDX_W'(WIDTH - 1));
        end
        rd_data_d = frame_q[rd_row];
    end

    // Pipeline, shift and frame state; everything clears on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_sr_q     <= '0;
            row_sr_q     <= '0;
            col_latch_q  <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            err_q        <= 1'b0;
            row_commit_q <= 1'b0;
            frame_done_q <= 1'b0;
            row_index_q  <= '0;
            rd_data_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            col_sr_q     <= col_sr_d;
            row_sr_q     <= row_sr_d;
            col_latch_q  <= col_latch_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            err_q        <= err_d;
            row_commit_q <= row_commit_d;
            frame_done_q <= frame_done_d;
            row_index_q  <= row_index_d;
            rd_data_q    <= rd_data_d;
            for (int i = 0; i < WIDTH; i++) begin
                frame_q[i] <= frame_d[i];
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign row_commit   = row_commit_q;
    assign row_index    = row_index_q;
    assign frame_done   = frame_done_q;
    assign err_multirow = err_q;
    assign blank        = oeb_s;

endmodule

// File: tb/tb_matrix_capture.sv
// tb/tb_matrix_capture.sv - self-checking bench for matrix_capture
module tb_matrix_capture;
    import matrix_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   rd_row;
    logic [W-1:0] rd_data;
    logic         row_commit;
    logic [3:0]   row_index;
    logic         frame_done;
    logic         err_multirow;
    logic         blank;

    matrix_capture_if lines();

    matrix_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .lines        (lines),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .row_commit   (row_commit),
        .row_index    (row_index),
        .frame_done   (frame_done),
        .err_multirow (err_multirow),
        .blank        (blank)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers and an array of rows.
    logic [15:0] m_col;
    logic [15:0] m_row;
    logic [15:0] m_frame [16];
    bit          m_err;
    int          m_commits;

    // Pulse observers.
    int commit_cnt = 0;
    int fd_cnt     = 0;
    int fd_bad     = 0;

    always @(negedge clk) begin
        if (row_commit === 1'b1) commit_cnt++;
        if (frame_done === 1'b1) begin
            fd_cnt++;
            if (row_commit !== 1'b1 || row_index !== 4'd15) fd_bad++;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        m_col = '0;
        m_row = '0;
        m_err = 1'b0;
        for (int r = 0; r < 16; r++) m_frame[r] = '0;
    endtask

    task automatic model_le();
        if ($countones(m_row) == 1) begin
            for (int k = 0; k < 16; k++) if (m_row[k]) m_frame[k] = m_col;
            m_commits++;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic shift_col(bit b);
        lines.csdi = b;
        lines.cclk = 1'b1;
        cyc(3);
        lines.cclk = 1'b0;
        cyc(3);
        m_col = (m_col << 1) | 16'(b);
    endtask

    task automatic shift_row(bit b);
        lines.rsdi = b;
        lines.rclk = 1'b1;
        cyc(3);
        lines.rclk = 1'b0;
        cyc(3);
        m_row = (m_row << 1) | 16'(b);
    endtask

    task automatic col_word(logic [15:0] v);
        for (int i = 15; i >= 0; i--) shift_col(v[i]);
    endtask

    task automatic row_word(logic [15:0] v);
        for (int i = 15; i >= 0; i--) shift_row(v[i]);
    endtask

    task automatic pulse_le();
        lines.le = 1'b1;
        cyc(3);
        lines.le = 1'b0;
        cyc(3);
        model_le();
    endtask

    task automatic check_frame(string tag);
        for (int r = 0; r < 16; r++) begin
            rd_row = 4'(r);
            cyc(1);
            chk($sformatf("%s_row%0d", tag, r), 32'(rd_data), 32'(m_frame[r]));
        end
    endtask

    initial begin
        logic [15:0] v;
        int          fd0, c0;

        reset      = 1'b0;
        rd_row     = '0;
        lines.rclk = 1'b0;
        lines.rsdi = 1'b0;
        lines.oeb  = 1'b1;
        lines.csdi = 1'b0;
        lines.cclk = 1'b0;
        lines.le   = 1'b0;
        m_commits  = 0;
        model_clear();
        cyc(2);

        chk("rst_rd_data",    32'(rd_data),      32'h0);
        chk("rst_row_commit", 32'(row_commit),   32'h0);
        chk("rst_frame_done", 32'(frame_done),   32'h0);
        chk("rst_row_index",  32'(row_index),    32'h0);
        chk("rst_err",        32'(err_multirow), 32'h0);
        chk("rst_blank",      32'(blank),        32'h1);

        reset = 1'b1;
        cyc(3);
        lines.oeb = 1'b0;
        cyc(4);
        chk("blank_follows_oeb", 32'(blank), 32'h0);

        // Single row: row_sr = 0x0004, column 0xA5C3, latency from le pin.
        shift_row(1'b1);
        shift_row(1'b0);
        shift_row(1'b0);
        col_word(16'hA5C3);
        lines.le = 1'b1;
        model_le();
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk($sformatf("lat_commit_c%0d", i), 32'(row_commit), (i == 4) ? 32'h1 : 32'h0);
        end
        chk("basic_row_index",  32'(row_index),  32'h2);
        chk("basic_frame_done", 32'(frame_done), 32'h0);
        rd_row = 4'd2;
        cyc(1);
        chk("basic_commit_one_cycle", 32'(row_commit), 32'h0);
        chk("basic_rd_data",          32'(rd_data),    32'hA5C3);
        lines.le = 1'b0;
        cyc(3);

        // Full frame, one pixel per row on the diagonal.
        fd0 = fd_cnt;
        c0  = commit_cnt;
        for (int r = 0; r < 16; r++) begin
            row_word(16'h0001 << r);
            col_word(16'h0001 << r);
            pulse_le();
        end
        chk("frame_commits",   32'(commit_cnt - c0), 32'd16);
        chk("frame_done_once", 32'(fd_cnt - fd0),    32'd1);
        chk("frame_done_row",  32'(fd_bad),          32'd0);
        check_frame("frame");

        // Two rows selected: no write, sticky error.
        c0 = commit_cnt;
        row_word(16'h0003);
        col_word(16'(($urandom)));
        pulse_le();
        chk("multi_no_commit", 32'(commit_cnt - c0), 32'd0);
        chk("multi_err",       32'(err_multirow),    32'(m_err));
        chk("multi_err_set",   32'(err_multirow),    32'h1);
        check_frame("multi");
        row_word(16'h0080);
        col_word(16'(($urandom)));
        pulse_le();
        chk("multi_err_sticky", 32'(err_multirow), 32'h1);
        chk("multi_valid_idx",  32'(row_index),    32'h7);

        // cclk and le rising in the same sampled cycle.
        row_word(16'h0020);
        col_word(16'h7FFF);
        lines.csdi = 1'b1;
        lines.cclk = 1'b1;
        lines.le   = 1'b1;
        cyc(3);
        lines.cclk = 1'b0;
        lines.le   = 1'b0;
        cyc(3);
        m_col = (m_col << 1) | 16'h1;
        model_le();
        rd_row = 4'd5;
        cyc(1);
        chk("same_cycle_latch", 32'(rd_data), 32'hFFFF);
        chk("same_cycle_model", 32'(rd_data), 32'(m_frame[5]));

        // Random rows (mostly one-hot) and random columns.
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 4) != 0) v = 16'h0001 << $urandom_range(0, 15);
            else v = 16'($urandom);
            row_word(v);
            col_word(16'($urandom));
            pulse_le();
        end
        check_frame("rand");
        chk("rand_commit_count", 32'(commit_cnt), 32'(m_commits));
        chk("rand_err",          32'(err_multirow), 32'(m_err));

        // Narrow cclk glitch (outcome undefined), then a full reload.
        lines.csdi = 1'b1;
        lines.cclk = 1'b1;
        cyc(1);
        lines.cclk = 1'b0;
        cyc(3);
        row_word(16'h0200);
        col_word(16'h1234);
        pulse_le();
        rd_row = 4'd9;
        cyc(1);
        chk("reload_after_glitch", 32'(rd_data), 32'h1234);
        shift_col(1'b1);
        pulse_le();
        rd_row = 4'd9;
        cyc(1);
        chk("wide_pulse_one_shift", 32'(rd_data), 32'h2469);

        // Reset in the middle of a column shift.
        shift_col(1'b1);
        shift_col(1'b0);
        lines.csdi = 1'b1;
        reset = 1'b0;
        cyc(1);
        chk("midrst_blank",   32'(blank),        32'h1);
        chk("midrst_err",     32'(err_multirow), 32'h0);
        chk("midrst_rd_data", 32'(rd_data),      32'h0);
        chk("midrst_row_idx", 32'(row_index),    32'h0);
        cyc(1);
        reset = 1'b1;
        model_clear();
        check_frame("midrst");
        row_word(16'h0800);
        col_word(16'(($urandom)));
        pulse_le();
        check_frame("postrst");
        chk("postrst_row_index", 32'(row_index),    32'hB);
        chk("postrst_err",       32'(err_multirow), 32'h0);
        chk("postrst_blank",     32'(blank),        32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_capture.md
Name: matrix_capture

Overview:
- Receive-side model of the LED-matrix serial interface driven by the screen block: RCLK/RSDI (row shift), CSDI/CCLK (column shift), LE (latch) and OEB (output enable).
- Oversamples the six lines in the system clock domain, deserialises row and column registers, and rebuilds a 16x16 frame buffer.
- The frame buffer is readable by row address.
- Used as on-chip readback and as the reference checker in game-level benches.

Parameters:
- WIDTH, 16, matrix rows and columns; also the width of both shift registers.
- SYNC_STAGES, 2, flip-flop synchroniser depth on each serial input (minimum 2).

Ports:
- clk  input  1  system clock; samples all serial lines.
- reset  input  1  asynchronous, active-low; 0 = in reset.
- rclk  input  1  row shift clock (async to clk).
- rsdi  input  1  row serial data.
- oeb  input  1  output enable, active-low.
- csdi  input  1  column serial data.
- cclk  input  1  column shift clock.
- le  input  1  column latch enable.
- rd_row  input  4  frame buffer read address.
- rd_data  output  WIDTH  pixel row at rd_row; bit i = column i, 1 = LED on.
- row_commit  output  1  one-cycle pulse when a row is written to the frame buffer.
- row_index  output  4  index of the last committed row.
- frame_done  output  1  one-cycle pulse when row WIDTH-1 is committed.
- err_multirow  output  1  sticky flag: an LE edge arrived with row_sr not one-hot.
- blank  output  1  synchronised oeb; 1 = display dark.

Behaviour:
- Synchronisation: rclk, rsdi, oeb, csdi, cclk and le each pass through SYNC_STAGES flops, then one more flop for edge detection. Rising edge = current synchronised value 1, previous value 0. Pulses narrower than 2 clk periods are not guaranteed to be seen.
- Column shift: on a cclk rising edge, col_sr <= {col_sr[WIDTH-2:0], csdi_s}. The first bit shifted ends in bit WIDTH-1.
- Row shift: on an rclk rising edge, row_sr <= {row_sr[WIDTH-2:0], rsdi_s}.
- Latch:
  - On an le rising edge, col_latch <= col_sr_next, where col_sr_next includes any cclk shift in the same cycle.
  - Same-cycle rule for rows: row decode uses row_sr_next, including any rclk shift in the same cycle.
- Commit:
  - If le rises and row_sr_next is one-hot, then on the next cycle frame[idx] <= col_sr_next, row_index <= idx, and row_commit = 1 for one cycle.
  - idx is the position of the set bit (bit k means row k).
  - frame_done pulses in the same cycle as row_commit when idx == WIDTH-1.
  - The commit happens regardless of blank; blank is informational only.
- Invalid row select: if row_sr_next is all zero or has more than one bit set when le rises, there is no write and no pulse. err_multirow is set to 1 and stays set until reset.
- Read port: rd_data is registered with 1-cycle latency from rd_row. On a write to the row being read in the same cycle, rd_data returns the old value; the new value appears one cycle later.
- Latency: from the le level change at the pin to row_commit is SYNC_STAGES + 2 clk cycles.
- Reset (reset = 0, asynchronous):
  - col_sr, col_latch, row_sr and every frame row clear to 0.
  - rd_data = 0, row_commit = 0, frame_done = 0, row_index = 0, err_multirow = 0.
  - blank = 1.
  - Edge-detect history clears to 0, so a line held high through reset release registers one rising edge once synchronised.
- Reset mid-shift: partially shifted data is discarded; there is no recovery of an interrupted row.
- There is no FSM beyond the edge/commit pipeline. Commit is a two-stage pipe: stage 1 detect + decode, stage 2 memory write + pulses.

Decomposition:
- Package matrix_pkg: MATRIX_WIDTH = 16, ROW_IDX_W = 4, a one-hot-to-index function, and an is_onehot function.
- Sub-module sync_edge (parameter STAGES): async-reset synchroniser plus rising-edge detector, outputs level and rise. Instantiated once per serial line; rsdi, csdi and oeb use only the level output.
- Frame storage is a register array in the top module, not a RAM macro: it needs async reset and is small.

Test Plan:
- Shift 1 into rsdi over 3 rclk edges, giving row_sr = 0x0004. Shift column pattern 0xA5C3, MSB first, over 16 cclk edges, then pulse le. Required: row_commit pulses 4 cycles after le rises, row_index = 2, rd_row = 2 gives rd_data = 0xA5C3 next cycle, frame_done = 0.
- Full frame: rows 0..15 each with pattern 0x0001<<row. Required: 16 row_commit pulses, and frame_done pulses only with row 15. Readback of every row matches.
- row_sr = 0x0003 (two rows) then le. Required: no row_commit, no frame change, err_multirow = 1. It stays 1 after a later valid commit.
- cclk and le rising in the same sampled cycle with csdi = 1. Required: the latched value includes the new LSB, e.g. col_sr 0x7FFF becomes committed 0xFFFF.
- Assert reset = 0 mid-column-shift after a committed frame. Required: all frame rows read 0, err_multirow = 0, blank = 1. A subsequent fresh row commits correctly.
- Glitch of 1 clk width on cclk. Required: no shift is guaranteed. A 3-cycle-wide cclk pulse produces exactly one shift.
